// File: rtl/sub_rx_pkg.sv
// rtl/sub_rx_pkg.sv - shared constants and helpers for the sub_rx receive FIFO
// Contents:
//   SUB_RX_CNT_W  width of the optional accepted-word counter
//   lvl_width()   bits needed to hold an occupancy of 0..depth
package sub_rx_pkg;

    localparam int SUB_RX_CNT_W = 32;

    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sub_rx_mem.sv
// rtl/sub_rx_mem.sv - DEPTH x TYPE_t register array, one write port, one async read port
// Ports:
//   clk    write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
// Storage is deliberately not reset; unread entries are masked by the owner.
module sub_rx_mem #(
    parameter type TYPE_t = logic,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  TYPE_t         wdata,
    input  logic [AW-1:0] raddr,
    output TYPE_t         rdata
);

    TYPE_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sub_rx.sv
// rtl/sub_rx.sv - receive side of the inverting sub stage: restores polarity into an elastic FIFO
// Ports:
//   clk, reset_l          clock and asynchronous active-low reset
//   in_valid/in_ready/in  inverted words from upstream (stored as ~in)
//   out_valid/out_ready/out  true-polarity words to downstream, out masked to 0 when empty
//   level, full, empty    occupancy and its flags
//   word_count            accepted-word counter, present only when SUB_RX_COUNT_EN is defined
module sub_rx
    import sub_rx_pkg::*;
#(
    parameter type TYPE_t = logic,
    parameter int  DEPTH  = 4,
    localparam int LVL_W  = lvl_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  TYPE_t                   in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output TYPE_t                   out,
    output logic [LVL_W-1:0]        level,
    output logic                    full,
`ifdef SUB_RX_COUNT_EN
    output logic                    empty,
    output logic [SUB_RX_CNT_W-1:0] word_count
`else
    output logic                    empty
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sub_rx: DEPTH must be a power of 2 and at least 2");
    end

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push;
    logic             pop;
    TYPE_t            rdata;

    // Flags come only from registered level, so in_ready never depends on out_ready:
    // a pop while full cannot open a same-cycle push slot.
    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign level     = level_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // Pointers are log2(DEPTH) wide, so +1 wraps modulo DEPTH for free.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    sub_rx_mem #(
        .TYPE_t (TYPE_t),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (~in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Mask stale or never-written storage whenever nothing is queued.
    assign out = empty ? TYPE_t'('0) : rdata;

`ifdef SUB_RX_COUNT_EN
    logic [SUB_RX_CNT_W-1:0] word_cnt_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            word_cnt_q <= '0;
        end else if (push) begin
            word_cnt_q <= word_cnt_q + SUB_RX_CNT_W'(1);
        end
    end

    assign word_count = word_cnt_q;
`endif

endmodule

// File: tb/tb_sub_rx.sv
// tb/tb_sub_rx.sv - directed scoreboard bench for sub_rx (byte data, DEPTH 4)
module tb_sub_rx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_l;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [2:0] level;
    logic       full;
    logic       empty;
`ifdef SUB_RX_COUNT_EN
    logic [31:0] word_count;
`endif

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] sb [$];
    logic [31:0] cnt_model = 0;
    logic [7:0] hold;

    sub_rx #(
        .TYPE_t (logic [7:0]),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .level      (level),
        .full       (full),
`ifdef SUB_RX_COUNT_EN
        .empty      (empty),
        .word_count (word_count)
`else
        .empty      (empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // At the falling edge: check all outputs against the model, then drive the
    // inputs for the coming rising edge and advance the model accordingly.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
        logic acc;
        logic pp;
        @(negedge clk);
        chk("level", {29'd0, level}, sb.size());
        chk("empty", {31'd0, empty}, sb.size() == 0);
        chk("full", {31'd0, full}, sb.size() == DEPTH);
        chk("in_ready", {31'd0, in_ready}, sb.size() != DEPTH);
        chk("out_valid", {31'd0, out_valid}, sb.size() != 0);
        if (sb.size() != 0) chk("out_data", {24'd0, out}, {24'd0, sb[0]});
        else                chk("out_masked", {24'd0, out}, 32'd0);
`ifdef SUB_RX_COUNT_EN
        chk("word_count", word_count, cnt_model);
`endif
        acc = iv && (sb.size() < DEPTH);
        pp  = ordy && (sb.size() > 0);
        in_valid  = iv;
        in        = d;
        out_ready = ordy;
        if (pp)  void'(sb.pop_front());
        if (acc) begin
            sb.push_back(~d);
            cnt_model = cnt_model + 32'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_l   = 1'b0;
        in_valid  = 1'b0;
        in        = 8'h00;
        out_ready = 1'b0;
        sb.delete();
        cnt_model = 0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
    endtask

    initial begin
        reset_l   = 1'b1;
        in_valid  = 1'b0;
        in        = 8'h00;
        out_ready = 1'b0;
        #1 reset_l = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        reset_l = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single word, no same-cycle bypass
        step(1'b1, 8'h5A, 1'b0);
        #1 chk("no_bypass", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_out", {24'd0, out}, 32'h0000_00A5);
        chk("single_level", {29'd0, level}, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        chk("single_empty", {31'd0, empty}, 32'd1);
        chk("single_masked", {24'd0, out}, 32'd0);

        // Fill to full, 5th word refused, drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h04, 1'b0);
        @(posedge clk); #1;
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_level", {29'd0, level}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_out", {24'd0, out}, 32'(8'hFF - 8'(i)));
        end
        step(1'b0, 8'h00, 1'b0);

        // Pop while full does not admit a same-cycle push
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
        step(1'b1, 8'h44, 1'b1);
        @(posedge clk); #1;
        chk("full_pop_level", {29'd0, level}, 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Simultaneous push/pop at level 2 across pointer wrap
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h20 + 8'(i), 1'b1);
            @(posedge clk); #1;
            chk("pp_level", {29'd0, level}, 32'd2);
        end

        // Backpressure: out held steady
        step(1'b0, 8'h00, 1'b0);
        hold = out;
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("bp_stable", {24'd0, out}, {24'd0, hold});
        end

        // Asynchronous reset mid-operation
        step(1'b1, 8'h30, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_level", {29'd0, level}, 32'd3);
        #2 reset_l = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_level", {29'd0, level}, 32'd0);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_out", {24'd0, out}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        cnt_model = 0;
        @(negedge clk);
        reset_l = 1'b1;
        step(1'b1, 8'h0F, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_out", {24'd0, out}, 32'h0000_00F0);
        step(1'b0, 8'h00, 1'b0);

`ifdef SUB_RX_COUNT_EN
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'h60 + 8'(i), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("count_7", word_count, 32'd7);
        step(1'b0, 8'h00, 1'b0);
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.word_cnt_q;
        cnt_model = 32'hFFFF_FFFF;
        step(1'b1, 8'h77, 1'b0);
        @(posedge clk); #1;
        chk("count_wrap", word_count, 32'd0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
